// File: rtl/f_issue_scoreboard_pkg.sv
// Shared finfo bit positions, long-unit defaults and timer state encoding
// for the FPU issue scoreboard.
package f_issue_scoreboard_pkg;

  // finfo vector layout produced by the FPU decoder
  localparam int FINFO_WEN0    = 0;
  localparam int FINFO_WEN1    = 1;
  localparam int FINFO_USEFS0  = 2;
  localparam int FINFO_USEFS1  = 3;
  localparam int FINFO_USEFT0  = 4;
  localparam int FINFO_USEFT1  = 5;
  localparam int FINFO_FCCINST = 6;
  localparam int FINFOCNT      = 8;

  // DIV/SQRT occupancy after handoff, in cycles
  localparam int FSB_LONG_LAT  = 16;

  typedef enum logic {
    FSB_IDLE = 1'b0,
    FSB_BUSY = 1'b1
  } fsb_state_e;

  // Expand a pair index plus {half1,half0} flags into the 32-bit half map
  function automatic logic [31:0] pair_halves(logic [3:0] pair, logic [1:0] h);
    logic [31:0] r;
    r = {30'b0, h} << {pair, 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/f_issue_scoreboard_if.sv
// Decode-side, execute-side and writeback signals of the issue scoreboard.
interface f_issue_scoreboard_if
  import f_issue_scoreboard_pkg::*;
#(
  parameter int FINFO_W = FINFOCNT
);
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [3:0]         id_fs, id_ft, id_fd;
  logic [FINFO_W-1:0] id_finfo;
  logic               id_long;
  logic               id_writecc;
  logic               iss_valid;
  logic               iss_ready;
  logic [3:0]         iss_fs, iss_ft, iss_fd;
  logic [FINFO_W-1:0] iss_finfo;
  logic               iss_long;
  logic               wb_valid;
  logic [3:0]         wb_fd;
  logic [1:0]         wb_wen;
  logic               wb_cc;
  logic [31:0]        fpr_pend;
  logic               long_busy;

  // Environment side: decoder, execute stage and writeback
  modport master (
    output flush, id_valid, id_fs, id_ft, id_fd, id_finfo, id_long, id_writecc,
           iss_ready, wb_valid, wb_fd, wb_wen, wb_cc,
    input  id_ready, iss_valid, iss_fs, iss_ft, iss_fd, iss_finfo, iss_long,
           fpr_pend, long_busy
  );

  // Scoreboard side
  modport slave (
    input  flush, id_valid, id_fs, id_ft, id_fd, id_finfo, id_long, id_writecc,
           iss_ready, wb_valid, wb_fd, wb_wen, wb_cc,
    output id_ready, iss_valid, iss_fs, iss_ft, iss_fd, iss_finfo, iss_long,
           fpr_pend, long_busy
  );
endinterface

// File: rtl/f_issue_scoreboard_long_timer.sv
// Occupancy timer for the unpipelined DIV/SQRT unit: busy for exactly
// LONG_LAT cycles following the cycle start_i is seen.
module f_sb_long_timer
  import f_issue_scoreboard_pkg::*;
#(
  parameter int LONG_LAT = FSB_LONG_LAT
) (
  input  logic clk,
  input  logic resetn,
  input  logic start_i,
  output logic busy_o
);
  localparam int CW = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;

  fsb_state_e    state_q;
  logic [CW-1:0] cnt_q;

  // IDLE -> BUSY loads LONG_LAT-1; BUSY counts down to 0 then returns to IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FSB_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FSB_IDLE: if (start_i) begin
          state_q <= FSB_BUSY;
          cnt_q   <= CW'(LONG_LAT - 1);
        end
        FSB_BUSY: begin
          if (cnt_q == '0) state_q <= FSB_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= FSB_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == FSB_BUSY);
endmodule

// File: rtl/f_issue_scoreboard.sv
// FPU issue stage: holds decoded ops until FPR-half, FCC and long-unit
// hazards clear, then presents them through a one-entry registered slot.
module f_issue_scoreboard
  import f_issue_scoreboard_pkg::*;
#(
  parameter int LONG_LAT = FSB_LONG_LAT,
  parameter int FINFO_W  = FINFOCNT
) (
  input logic clk,
  input logic resetn,
  f_issue_scoreboard_if.slave sb
);
  logic               iss_valid_q, iss_valid_d;
  logic [3:0]         iss_fs_q, iss_ft_q, iss_fd_q;
  logic [FINFO_W-1:0] iss_finfo_q;
  logic               iss_long_q, iss_wcc_q;
  logic [31:0]        fpr_pend_q, fpr_pend_d;
  logic               cc_pend_q, cc_pend_d;

  logic [31:0] wbclr, slot_wen, eff, need;
  logic        haz_fpr, haz_cc, haz_long, hazard;
  logic        accept, handoff, long_busy;

  // Same-cycle writeback bypass plus halves the slot op will write
  always_comb begin
    wbclr    = sb.wb_valid ? pair_halves(sb.wb_fd, sb.wb_wen) : '0;
    slot_wen = pair_halves(iss_fd_q, {iss_finfo_q[FINFO_WEN1], iss_finfo_q[FINFO_WEN0]});
    eff      = (fpr_pend_q & ~wbclr) | (iss_valid_q ? slot_wen : '0);
    need     = pair_halves(sb.id_fs, {sb.id_finfo[FINFO_USEFS1], sb.id_finfo[FINFO_USEFS0]})
             | pair_halves(sb.id_ft, {sb.id_finfo[FINFO_USEFT1], sb.id_finfo[FINFO_USEFT0]})
             | pair_halves(sb.id_fd, {sb.id_finfo[FINFO_WEN1],   sb.id_finfo[FINFO_WEN0]});
    haz_fpr  = |(need & eff);
    haz_cc   = sb.id_finfo[FINFO_FCCINST]
             & ((cc_pend_q & ~sb.wb_cc) | (iss_valid_q & iss_wcc_q));
    haz_long = sb.id_long & (long_busy | (iss_valid_q & iss_long_q));
    hazard   = haz_fpr | haz_cc | haz_long;
  end

  assign sb.id_ready = resetn & ~sb.flush & ~hazard & (~iss_valid_q | sb.iss_ready);
  assign accept      = sb.id_valid & sb.id_ready;
  assign handoff     = iss_valid_q & sb.iss_ready;

  // Pending bits are set when the op leaves the slot; set wins over writeback clear
  always_comb begin
    fpr_pend_d  = (fpr_pend_q & ~wbclr) | (handoff ? slot_wen : '0);
    cc_pend_d   = (cc_pend_q & ~sb.wb_cc) | (handoff & iss_wcc_q);
    iss_valid_d = iss_valid_q;
    if (accept)                  iss_valid_d = 1'b1;
    else if (handoff || sb.flush) iss_valid_d = 1'b0;
  end

  // Issue slot and pending state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iss_valid_q <= 1'b0;
      iss_fs_q    <= '0;
      iss_ft_q    <= '0;
      iss_fd_q    <= '0;
      iss_finfo_q <= '0;
      iss_long_q  <= 1'b0;
      iss_wcc_q   <= 1'b0;
      fpr_pend_q  <= '0;
      cc_pend_q   <= 1'b0;
    end else begin
      iss_valid_q <= iss_valid_d;
      fpr_pend_q  <= fpr_pend_d;
      cc_pend_q   <= cc_pend_d;
      if (accept) begin
        iss_fs_q    <= sb.id_fs;
        iss_ft_q    <= sb.id_ft;
        iss_fd_q    <= sb.id_fd;
        iss_finfo_q <= sb.id_finfo;
        iss_long_q  <= sb.id_long;
        iss_wcc_q   <= sb.id_writecc;
      end
    end
  end

  f_sb_long_timer #(.LONG_LAT(LONG_LAT)) u_long (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (handoff & iss_long_q),
    .busy_o  (long_busy)
  );

  assign sb.iss_valid = iss_valid_q;
  assign sb.iss_fs    = iss_fs_q;
  assign sb.iss_ft    = iss_ft_q;
  assign sb.iss_fd    = iss_fd_q;
  assign sb.iss_finfo = iss_finfo_q;
  assign sb.iss_long  = iss_long_q;
  assign sb.fpr_pend  = fpr_pend_q;
  assign sb.long_busy = long_busy;
endmodule
